fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
Parametrised single-clock synchronous FIFO. It is the successor to the fixed 8-bit x 128 FIFO and generalises data width and depth. It adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer datapaths in the lab designs as a drop-in buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 128, number of entries; power of two, >=4
AF_THRESH, DEPTH-4, AlmostFull asserts when Count >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, AlmostEmpty asserts when Count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
Din  in  DATA_W  write data
WR_EN  in  1  write request
RD_EN  in  1  read request (FWFT: pop the displayed word)
DOut  out  DATA_W  read data
Empty  out  1  no readable word
Full  out  1  Count == DEPTH
AlmostFull  out  1  Count >= AF_THRESH
AlmostEmpty  out  1  Count <= AE_THRESH
Count  out  clog2(DEPTH)+1  occupancy, 0..DEPTH
Overflow  out  1  one-cycle pulse: write rejected
Underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset: one clock, synchronous and active-high. On RST high at an edge: wr_ptr=rd_ptr=0, Count=0, DOut=0, Empty=1, Full=0, AlmostEmpty=1, AlmostFull=0, Overflow=Underflow=0. Memory contents are not cleared. RST dominates WR_EN/RD_EN. A reset mid-operation discards all stored data.
- Pointers: addr width clog2(DEPTH); wrap naturally from DEPTH-1 to 0.
- Read accepted iff RD_EN && Count>0. Write accepted iff WR_EN && (Count<DEPTH || read accepted same edge).
- Simultaneous write and read:
  - Count>0: both accepted, Count unchanged.
  - When Full: both accepted, stays Full.
  - When Empty: write accepted, read rejected, Underflow pulses, Count becomes 1.
- Rejected write: no state change except an Overflow pulse the next cycle. Rejected read likewise produces an Underflow pulse.
- Count: +1 on write only, -1 on read only, unchanged otherwise. Status flags are combinational from the registered Count, so they change on the same edge as Count.
- Standard mode (FWFT=0):
  - DOut is registered and takes mem[rd_ptr] on the edge the read is accepted (1-cycle latency).
  - DOut holds its value otherwise, including on a rejected read.
  - Empty = (Count==0).
- FWFT mode (FWFT=1):
  - DOut = mem[rd_ptr] whenever Count>0. The first word is visible the cycle after the write edge.
  - RD_EN advances to the next word. Empty = (Count==0).
  - DOut is don't-care while Empty, and drives 0 after reset.
- Data ordering is strictly first-in first-out; no word is lost or duplicated across pointer wrap.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2 function
  - default threshold constants (AF_MARGIN=4, AE_MARGIN=4)
  - the FWFT mode encodings (MODE_STD=0, MODE_FWFT=1)
- Sub-module fifo_ram: DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port. The top level owns pointers, count, flags and the DOut register.

Test Plan:
Bench config is DATA_W=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2, run for both FWFT=0 and FWFT=1.
- Fill: after RST, write 1..16 -> Count steps 1..16; AlmostEmpty drops at Count=3; AlmostFull rises at Count=12; Full=1 at 16.
- Overflow: with FIFO full, write 255 -> Overflow=1 for one cycle; Count stays 16; 255 never appears on read.
- Drain: read 16 times -> DOut sequence 1..16 (FWFT=0: one cycle after each RD_EN; FWFT=1: before each pop); Empty=1 at end. A 17th read -> Underflow pulse, DOut holds 16 (FWFT=0).
- Simultaneous: on an empty FIFO, WR_EN+RD_EN with Din=101 -> Underflow pulse, Count=1. Then 10 cycles of WR_EN+RD_EN with Din=102..111 -> Count stays 1; reads return 101..110.
- Wrap: 40 interleaved writes/reads of 0..39 at occupancy 5 -> FIFO order preserved across pointer wrap.
- Reset mid-operation: at Count=9, pulse RST for one cycle -> Count=0, Empty=1, Full=0, DOut=0. The next write/read of 0xA5 returns 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers, default threshold margins and read-mode encodings for fifo_param.
package fifo_pkg;
    localparam int AF_MARGIN = 4;
    localparam int AE_MARGIN = 4;
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage, synchronous write port, asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with thresholds, occupancy count,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 128,
    parameter int AF_THRESH = DEPTH - AF_MARGIN,
    parameter int AE_THRESH = AE_MARGIN,
    parameter int FWFT      = MODE_STD
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_W-1:0]        Din,
    input  logic                     WR_EN,
    input  logic                     RD_EN,
    output logic [DATA_W-1:0]        DOut,
    output logic                     Empty,
    output logic                     Full,
    output logic                     AlmostFull,
    output logic                     AlmostEmpty,
    output logic [clog2(DEPTH):0]    Count,
    output logic                     Overflow,
    output logic                     Underflow
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, rdata;
    logic              ovf_q, unf_q, rd_ok, wr_ok;
    fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (CLK),
        .we_i   (wr_ok),
        .waddr_i(wr_ptr_q),
        .wdata_i(Din),
        .raddr_i(rd_ptr_q),
        .rdata_o(rdata)
    );
    // A full FIFO can still take a write when a read frees a slot on the same edge.
    always_comb begin
        rd_ok   = RD_EN && (count_q != '0);
        wr_ok   = WR_EN && ((count_q != FULL_C) || rd_ok);
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rd_ok) dout_q <= rdata;
            count_q <= count_d;
            ovf_q   <= WR_EN && !wr_ok;
            unf_q   <= RD_EN && !rd_ok;
        end
    end
    assign DOut        = (FWFT == MODE_FWFT) ? ((count_q == '0) ? '0 : rdata) : dout_q;
    assign Empty       = (count_q == '0);
    assign Full        = (count_q == FULL_C);
    assign AlmostFull  = (count_q >= CW'(AF_THRESH));
    assign AlmostEmpty = (count_q <= CW'(AE_THRESH));
    assign Count       = count_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed bench driving a standard-read and an FWFT instance in lockstep.
module tb_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] s_dout, f_dout;
    logic       s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic       f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_cnt, f_cnt;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) u_std (
        .CLK(clk), .RST(rst), .Din(din), .WR_EN(wr_en), .RD_EN(rd_en), .DOut(s_dout),
        .Empty(s_empty), .Full(s_full), .AlmostFull(s_af), .AlmostEmpty(s_ae),
        .Count(s_cnt), .Overflow(s_ovf), .Underflow(s_unf)
    );
    fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .CLK(clk), .RST(rst), .Din(din), .WR_EN(wr_en), .RD_EN(rd_en), .DOut(f_dout),
        .Empty(f_empty), .Full(f_full), .AlmostFull(f_af), .AlmostEmpty(f_ae),
        .Count(f_cnt), .Overflow(f_ovf), .Underflow(f_unf)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask
    task automatic chk_state(input string tag, input int cnt, input logic emp, input logic ful,
                             input logic af, input logic ae);
        chk({tag, "_s_cnt"}, 32'(s_cnt), 32'(cnt));
        chk({tag, "_f_cnt"}, 32'(f_cnt), 32'(cnt));
        chk({tag, "_s_empty"}, 32'(s_empty), 32'(emp));
        chk({tag, "_f_empty"}, 32'(f_empty), 32'(emp));
        chk({tag, "_s_full"}, 32'(s_full), 32'(ful));
        chk({tag, "_f_full"}, 32'(f_full), 32'(ful));
        chk({tag, "_s_af"}, 32'(s_af), 32'(af));
        chk({tag, "_f_af"}, 32'(f_af), 32'(af));
        chk({tag, "_s_ae"}, 32'(s_ae), 32'(ae));
        chk({tag, "_f_ae"}, 32'(f_ae), 32'(ae));
    endtask
    task automatic chk_pulses(input string tag, input logic ovf, input logic unf);
        chk({tag, "_s_ovf"}, 32'(s_ovf), 32'(ovf));
        chk({tag, "_f_ovf"}, 32'(f_ovf), 32'(ovf));
        chk({tag, "_s_unf"}, 32'(s_unf), 32'(unf));
        chk({tag, "_f_unf"}, 32'(f_unf), 32'(unf));
    endtask
    initial begin
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        chk_state("reset", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_pulses("reset", 1'b0, 1'b0);
        chk("reset_s_dout", 32'(s_dout), 32'h0);
        chk("reset_f_dout", 32'(f_dout), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk_state("fill", i, 1'b0, i == 16, i >= 12, i <= 2);
            chk("fill_f_dout", 32'(f_dout), 32'd1);
            chk("fill_s_dout", 32'(s_dout), 32'd0);
        end
        cyc(1'b1, 1'b0, 8'd255);
        chk_pulses("ovf", 1'b1, 1'b0);
        chk_state("ovf", 16, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'd0);
        chk_pulses("ovf_end", 1'b0, 1'b0);
        chk_state("ovf_end", 16, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_f_dout", 32'(f_dout), 32'(i));
            cyc(1'b0, 1'b1, 8'd0);
            chk("drain_s_dout", 32'(s_dout), 32'(i));
            chk_state("drain", 16 - i, i == 16, 1'b0, (16 - i) >= 12, (16 - i) <= 2);
        end
        cyc(1'b0, 1'b1, 8'd0);
        chk_pulses("unf", 1'b0, 1'b1);
        chk("unf_s_dout", 32'(s_dout), 32'd16);
        chk_state("unf", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'd0);
        chk_pulses("unf_end", 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'd101);
        chk_pulses("sim_empty", 1'b0, 1'b1);
        chk_state("sim_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sim_empty_s_dout", 32'(s_dout), 32'd16);
        for (int k = 0; k < 10; k++) begin
            chk("sim_f_dout", 32'(f_dout), 32'(101 + k));
            cyc(1'b1, 1'b1, 8'(102 + k));
            chk("sim_s_dout", 32'(s_dout), 32'(101 + k));
            chk_state("sim", 1, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_pulses("sim", 1'b0, 1'b0);
        end
        chk("sim_last_f_dout", 32'(f_dout), 32'd111);
        cyc(1'b0, 1'b1, 8'd0);
        chk("sim_last_s_dout", 32'(s_dout), 32'd111);
        chk_state("sim_last", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(i));
        chk_state("wrap_pre", 5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i < 40; i++) begin
            chk("wrap_f_dout", 32'(f_dout), 32'(i - 5));
            cyc(1'b1, 1'b1, 8'(i));
            chk("wrap_s_dout", 32'(s_dout), 32'(i - 5));
            chk("wrap_cnt", 32'(s_cnt), 32'd5);
        end
        for (int i = 35; i < 40; i++) begin
            chk("wrap_tail_f_dout", 32'(f_dout), 32'(i));
            cyc(1'b0, 1'b1, 8'd0);
            chk("wrap_tail_s_dout", 32'(s_dout), 32'(i));
        end
        chk_state("wrap_end", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(i));
        chk_state("mid", 9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 8'd77);
        chk("mid_s_dout", 32'(s_dout), 32'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'd200);
        rst = 1'b0;
        chk_state("rst_mid", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_pulses("rst_mid", 1'b0, 1'b0);
        chk("rst_mid_s_dout", 32'(s_dout), 32'h0);
        chk("rst_mid_f_dout", 32'(f_dout), 32'h0);
        cyc(1'b1, 1'b0, 8'hA5);
        chk("post_f_dout", 32'(f_dout), 32'hA5);
        chk_state("post_wr", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'd0);
        chk("post_s_dout", 32'(s_dout), 32'hA5);
        chk_state("post_rd", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
